// File: rtl/exp_taylor_sched_if.sv
// ----------------------------------------------------------------------------
// exp_taylor_sched_if
//   Bundles everything the exp scheduler exchanges with the outside world:
//   the requester side (req_*), the consumer side (rsp_*), the exp unit
//   side (u_*) and the busy status flag.
//
//   req_valid   [NREQ]              per-requester operand valid
//   req_data    [NREQ][FRACWIDTH]   operand of requester i (flat layout is
//                                   bits [i*FRACWIDTH +: FRACWIDTH])
//   req_ready   [NREQ]              one-hot accept, grant cycle only
//   rsp_valid / rsp_ready           result handshake
//   rsp_data    [FRACWIDTH]         exp result (0 on timeout)
//   rsp_id      [IDW]               requester owning rsp_data
//   rsp_timeout                     operation was aborted
//   u_start / u_data                start pulse + operand to the exp unit
//   u_read                          early-terminate/read request to the unit
//   u_result / u_valid              exp unit result
//   busy                            scheduler not idle
//
//   modport slave  : the scheduler
//   modport master : the environment (requesters, consumer, exp unit)
// ----------------------------------------------------------------------------
interface exp_taylor_sched_if #(
  parameter int FRACWIDTH = 12,
  parameter int NREQ      = 4,
  parameter int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]                req_valid;
  logic [NREQ-1:0][FRACWIDTH-1:0] req_data;
  logic [NREQ-1:0]                req_ready;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [FRACWIDTH-1:0]           rsp_data;
  logic [IDW-1:0]                 rsp_id;
  logic                           rsp_timeout;
  logic                           u_start;
  logic [FRACWIDTH-1:0]           u_data;
  logic                           u_read;
  logic [FRACWIDTH-1:0]           u_result;
  logic                           u_valid;
  logic                           busy;

  modport slave (
    input  req_valid, req_data, rsp_ready, u_result, u_valid,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_timeout,
           u_start, u_data, u_read, busy
  );

  modport master (
    output req_valid, req_data, rsp_ready, u_result, u_valid,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_timeout,
           u_start, u_data, u_read, busy
  );
endinterface

// File: rtl/exp_taylor_sched.sv
// ----------------------------------------------------------------------------
// exp_taylor_sched
//   Round-robin front end for a single, non-pipelined exp (Taylor series)
//   unit. One operation is in flight at a time:
//
//     IDLE  : pick a requester (round robin from last_grant+1), accept it and
//             pulse u_start with its operand, all combinationally.
//     RUN   : let the series iterate; cyc counts cycles since the grant.
//     DRAIN : u_read asks the unit to terminate and present its result.
//     RESP  : hold the result until the consumer takes it.
//
//   A qualifying u_valid in RUN/DRAIN captures u_result. If none arrives
//   before cyc reaches TIMEOUT the operation is aborted with rsp_data=0 and
//   rsp_timeout=1. Capture beats timeout when both happen in one cycle.
//
//   Ports: clk, rst_n (async, active low) and the slave side of
//   exp_taylor_sched_if (see the interface header for signal meanings).
//
//   Legal parameters: 2 <= READ_CYC < TIMEOUT < 2**CNTW.
// ----------------------------------------------------------------------------
module exp_taylor_sched #(
  parameter int FRACWIDTH = 12,
  parameter int NREQ      = 4,
  parameter int READ_CYC  = 6,
  parameter int TIMEOUT   = 31,
  parameter int CNTW      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  exp_taylor_sched_if.slave  bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Transitions are decided on the value cyc is about to take, so the
  // registered state lines up with the counter: DRAIN is entered holding
  // cyc == READ_CYC-1 (u_read first high READ_CYC cycles after the grant),
  // and RESP is entered as cyc would reach TIMEOUT.
  localparam logic [CNTW-1:0] CYC_TMO   = CNTW'(TIMEOUT);
  localparam logic [CNTW-1:0] CYC_DRAIN = CNTW'(READ_CYC - 1);
  // u_valid below this count is a leftover from the previous operation.
  localparam logic [CNTW-1:0] CYC_QUAL  = CNTW'(2);
  localparam logic [CNTW-1:0] CYC_ONE   = CNTW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state, state_nx;
  logic [CNTW-1:0]       cyc, cyc_nx, cyc_inc;
  logic [IDW-1:0]        last_grant;
  logic [IDW-1:0]        gnt_idx;
  logic                  gnt_any;
  logic                  take_gnt;
  logic                  cap;
  logic                  tmo;
  logic [NREQ-1:0]       req_ready_c;
  logic                  u_start_c;
  logic [FRACWIDTH-1:0]  u_data_c;
  logic [FRACWIDTH-1:0]  rsp_data_q;
  logic [IDW-1:0]        rsp_id_q;
  logic                  rsp_tmo_q;

  // --------------------------------------------------------------------------
  // Round-robin pick: the first valid requester at offset 1..NREQ from
  // last_grant. Offsets are walked from far to near so the nearest valid one
  // is written last and wins. Returns {found, index}.
  // --------------------------------------------------------------------------
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                           input logic [IDW-1:0]  last);
    logic [IDW:0]   r;
    logic [IDW-1:0] idx;
    r = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IDW'((int'(last) + i) % NREQ);
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    {gnt_any, gnt_idx} = rr_pick(bus.req_valid, last_grant);
  end

  // Saturating increment; the FSM leaves RUN/DRAIN before saturation
  // matters, the clamp just keeps the counter from wrapping.
  assign cyc_inc = (cyc == CYC_TMO) ? cyc : cyc + CYC_ONE;

  // --------------------------------------------------------------------------
  // Next state and combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx    = state;
    cyc_nx      = cyc;
    take_gnt    = 1'b0;
    cap         = 1'b0;
    tmo         = 1'b0;
    req_ready_c = '0;
    u_start_c   = 1'b0;
    u_data_c    = '0;

    case (state)
      IDLE: begin
        if (gnt_any) begin
          take_gnt             = 1'b1;
          req_ready_c[gnt_idx] = 1'b1;
          u_start_c            = 1'b1;
          u_data_c             = bus.req_data[gnt_idx];
          cyc_nx               = '0;
          state_nx             = RUN;
        end
      end

      RUN, DRAIN: begin
        cyc_nx = cyc_inc;
        if (bus.u_valid && (cyc >= CYC_QUAL)) begin
          cap      = 1'b1;
          state_nx = RESP;
        end else if (cyc_inc == CYC_TMO) begin
          tmo      = 1'b1;
          state_nx = RESP;
        end else if ((state == RUN) && (cyc_inc == CYC_DRAIN)) begin
          state_nx = DRAIN;
        end
      end

      RESP: begin
        if (bus.rsp_ready) state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cyc        <= '0;
      last_grant <= IDW'(NREQ - 1);
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_tmo_q  <= 1'b0;
    end else begin
      state <= state_nx;
      cyc   <= cyc_nx;
      if (take_gnt) begin
        last_grant <= gnt_idx;
        rsp_id_q   <= gnt_idx;
      end
      if (cap) begin
        rsp_data_q <= bus.u_result;
        rsp_tmo_q  <= 1'b0;
      end else if (tmo) begin
        rsp_data_q <= '0;
        rsp_tmo_q  <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The grant path is combinational from req_valid, and the state
  // sits in IDLE during reset, so the grant outputs are masked by rst_n to
  // keep them quiet while reset is held.
  // --------------------------------------------------------------------------
  assign bus.req_ready   = rst_n ? req_ready_c : '0;
  assign bus.u_start     = rst_n & u_start_c;
  assign bus.u_data      = rst_n ? u_data_c : '0;
  assign bus.u_read      = (state == DRAIN);
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_timeout = rsp_tmo_q;
  assign bus.busy        = (state != IDLE);

  // --------------------------------------------------------------------------
  // Protocol properties
  // --------------------------------------------------------------------------
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready));

  a_start_idle_only: assert property (@(posedge clk) disable iff (!rst_n)
    bus.u_start |-> (state == IDLE));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.rsp_valid && !bus.rsp_ready) |=>
      (bus.rsp_valid && $stable(bus.rsp_data) && $stable(bus.rsp_id) &&
       $stable(bus.rsp_timeout)));

endmodule

// File: tb/tb_exp_taylor_sched.sv
// ----------------------------------------------------------------------------
// tb_exp_taylor_sched
//   Directed table of operations, hand sequences for reset / round-robin
//   order, then randomized operations checked against a reference model
//   (round-robin search plus closed-form response latency).
//   Inputs change 1 time unit after the rising edge, outputs are sampled
//   1-3 units later.
// ----------------------------------------------------------------------------
module tb_exp_taylor_sched;
  localparam int FW  = 12;
  localparam int NR  = 4;
  localparam int RDC = 6;
  localparam int TMO = 31;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exp_taylor_sched_if #(.FRACWIDTH(FW), .NREQ(NR)) bus();

  exp_taylor_sched #(
    .FRACWIDTH(FW), .NREQ(NR), .READ_CYC(RDC), .TIMEOUT(TMO), .CNTW(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc_n  = 0;

  // exp unit model: pulses u_valid um_delay cycles after u_read first rises
  // (never when um_delay < 0); um_early adds stale pulses on the first two
  // cycles after the grant.
  int            um_delay = -1;
  logic [FW-1:0] um_result = '0;
  bit            um_early = 1'b0;
  bit            rd_seen = 1'b0;
  int            rd_cyc = 0;
  int            g_cyc = 0;

  typedef struct {
    logic [3:0]         vld;
    logic [3:0][FW-1:0] data;
    int                 d;
    logic [FW-1:0]      res;
    bit                 early;
    int                 stall;
    int                 e_id;
    logic [FW-1:0]      e_ud;
    logic [FW-1:0]      e_rd;
    bit                 e_tmo;
    int                 e_lat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
    if (um_early && (cyc_n == g_cyc + 1 || cyc_n == g_cyc + 2)) begin
      bus.u_valid  = 1'b1;
      bus.u_result = 12'hFFF;
    end else if (rd_seen && um_delay >= 0 && cyc_n == rd_cyc + um_delay) begin
      bus.u_valid  = 1'b1;
      bus.u_result = um_result;
    end else begin
      bus.u_valid  = 1'b0;
      bus.u_result = FW'($urandom);
    end
    #1;
    if (bus.u_read && !rd_seen) begin
      rd_seen = 1'b1;
      rd_cyc  = cyc_n;
    end
  endtask

  // One full operation from an IDLE cycle: grant, wait for response, stall,
  // handshake. Ends in the IDLE cycle after the handshake.
  task automatic run_op(input string tag, input logic [3:0] vld,
                        input logic [3:0][FW-1:0] data, input int d,
                        input logic [FW-1:0] res, input bit early, input int stall,
                        input int e_id, input logic [FW-1:0] e_ud,
                        input logic [FW-1:0] e_rd, input bit e_tmo, input int e_lat);
    int lat;
    int rdl;
    bit quiet;
    bit stable;
    bus.req_valid = vld;
    bus.req_data  = data;
    bus.rsp_ready = 1'b0;
    um_delay  = d;
    um_result = res;
    um_early  = early;
    rd_seen   = 1'b0;
    g_cyc     = cyc_n;
    #1;
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(1) << e_id);
    chk({tag, " u_start"}, 32'(bus.u_start), 1);
    chk({tag, " u_data"}, 32'(bus.u_data), 32'(e_ud));
    lat = -1;
    rdl = -1;
    quiet = 1'b1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      tick();
      if (bus.u_start || bus.req_ready != '0 || !bus.busy) quiet = 1'b0;
      if (bus.u_read && rdl < 0) rdl = cyc_n - g_cyc;
      if (bus.rsp_valid) lat = cyc_n - g_cyc;
    end
    chk({tag, " quiet_in_flight"}, 32'(quiet), 1);
    chk({tag, " u_read_latency"}, rdl, RDC);
    chk({tag, " rsp_latency"}, lat, e_lat);
    chk({tag, " rsp_id"}, 32'(bus.rsp_id), e_id);
    chk({tag, " rsp_data"}, 32'(bus.rsp_data), 32'(e_rd));
    chk({tag, " rsp_timeout"}, 32'(bus.rsp_timeout), 32'(e_tmo));
    stable = 1'b1;
    for (int s = 0; s < stall; s++) begin
      tick();
      if (!bus.rsp_valid || bus.rsp_data != e_rd || bus.rsp_id != 2'(e_id) ||
          bus.rsp_timeout != e_tmo || bus.u_start || bus.req_ready != '0)
        stable = 1'b0;
    end
    if (stall > 0) chk({tag, " rsp_hold"}, 32'(stable), 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, " rsp_valid_after_hs"}, 32'(bus.rsp_valid), 0);
    chk({tag, " busy_after_hs"}, 32'(bus.busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][FW-1:0] dat;
    int last_m;
    // table: starts with last_grant = 0 (after the 0,1,2,3,0 sequence)
    tbl[0] = '{4'b0010, {12'h333, 12'h222, 12'h400, 12'h111}, 2, 12'h9B4, 0, 0,
               1, 12'h400, 12'h9B4, 0, 9};
    tbl[1] = '{4'b1111, {12'hA03, 12'hA02, 12'hA01, 12'hA00}, 5, 12'h7A1, 0, 10,
               2, 12'hA02, 12'h7A1, 0, 12};
    tbl[2] = '{4'b0011, {12'hB03, 12'hB02, 12'hB01, 12'hB00}, -1, 12'h555, 0, 2,
               0, 12'hB00, 12'h000, 1, 32};
    tbl[3] = '{4'b1001, {12'hC03, 12'hC02, 12'hC01, 12'hC00}, 25, 12'hABC, 0, 0,
               3, 12'hC03, 12'hABC, 0, 32};
    tbl[4] = '{4'b0100, {12'hD03, 12'hD02, 12'hD01, 12'hD00}, 26, 12'h777, 0, 1,
               2, 12'hD02, 12'h000, 1, 32};
    tbl[5] = '{4'b0001, {12'hE03, 12'hE02, 12'hE01, 12'hE00}, 1, 12'h001, 0, 0,
               0, 12'hE00, 12'h001, 0, 8};
    tbl[6] = '{4'b1010, {12'hF03, 12'hF02, 12'hF01, 12'hF00}, 2, 12'h123, 1, 0,
               1, 12'hF01, 12'h123, 0, 9};

    bus.req_valid = 4'hF;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    bus.u_valid   = 1'b0;
    bus.u_result  = '0;

    // reset state, with requests pending
    repeat (2) @(posedge clk);
    #2;
    chk("rst req_ready", 32'(bus.req_ready), 0);
    chk("rst u_start", 32'(bus.u_start), 0);
    chk("rst u_read", 32'(bus.u_read), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst rsp_data", 32'(bus.rsp_data), 0);
    chk("rst rsp_id", 32'(bus.rsp_id), 0);
    chk("rst rsp_timeout", 32'(bus.rsp_timeout), 0);
    bus.req_valid = 4'h0;
    rst_n = 1'b1;
    tick();
    chk("idle no_req u_start", 32'(bus.u_start), 0);
    chk("idle no_req busy", 32'(bus.busy), 0);

    // all requesters held valid: grant order 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) dat[j] = FW'(12'h0A0 + j);
      run_op($sformatf("rr%0d", i), 4'hF, dat, 2, FW'(12'h500 + i), 0, 0,
             i % 4, dat[i % 4], FW'(12'h500 + i), 0, 9);
    end

    // directed table
    for (int i = 0; i < 7; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].vld, tbl[i].data, tbl[i].d, tbl[i].res,
             tbl[i].early, tbl[i].stall, tbl[i].e_id, tbl[i].e_ud, tbl[i].e_rd,
             tbl[i].e_tmo, tbl[i].e_lat);

    // reset in DRAIN discards the operation; first grant after is lowest index
    bus.req_valid = 4'b0100;
    bus.req_data  = {12'h043, 12'h042, 12'h041, 12'h040};
    um_delay = -1;
    um_early = 1'b0;
    rd_seen  = 1'b0;
    g_cyc    = cyc_n;
    for (int k = 0; k < 20 && !bus.u_read; k++) tick();
    tick();
    chk("drain before reset u_read", 32'(bus.u_read), 1);
    rst_n = 1'b0;
    #1;
    chk("mid rst req_ready", 32'(bus.req_ready), 0);
    chk("mid rst u_start", 32'(bus.u_start), 0);
    chk("mid rst u_data", 32'(bus.u_data), 0);
    chk("mid rst u_read", 32'(bus.u_read), 0);
    chk("mid rst busy", 32'(bus.busy), 0);
    chk("mid rst rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mid rst rsp_data", 32'(bus.rsp_data), 0);
    chk("mid rst rsp_id", 32'(bus.rsp_id), 0);
    chk("mid rst rsp_timeout", 32'(bus.rsp_timeout), 0);
    bus.req_valid = 4'b1001;
    #1;
    rst_n = 1'b1;
    run_op("post_rst", 4'b1001, {12'h653, 12'h652, 12'h651, 12'h650}, 3, 12'h2C4, 0, 1,
           0, 12'h650, 12'h2C4, 0, 10);

    // randomized operations against the reference model
    last_m = 0;
    for (int n = 0; n < 40; n++) begin
      logic [3:0] vld;
      logic [FW-1:0] res;
      int d, stall, g, lat, k;
      bit tmo;
      logic [FW-1:0] rd;
      if ($urandom_range(0, 3) == 0) begin
        bus.req_valid = 4'h0;
        #1;
        chk("rnd gap no_grant", 32'(bus.u_start) | 32'(bus.req_ready), 0);
        repeat ($urandom_range(1, 3)) tick();
        chk("rnd gap busy", 32'(bus.busy), 0);
      end
      vld = 4'($urandom_range(1, 15));
      for (int j = 0; j < 4; j++) dat[j] = FW'($urandom);
      d = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 28));
      res = FW'($urandom);
      stall = $urandom_range(0, 3);
      g = -1;
      for (int o = 1; o <= NR; o++)
        if (g < 0 && vld[(last_m + o) % NR]) g = (last_m + o) % NR;
      last_m = g;
      k = RDC + d;
      if (d < 0 || k > TMO) begin
        tmo = 1'b1; rd = '0; lat = TMO + 1;
      end else begin
        tmo = 1'b0; rd = res; lat = k + 1;
      end
      run_op($sformatf("rnd%0d", n), vld, dat, d, res, 0, stall, g, dat[g], rd, tmo, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
